// File: rtl/alu_pipe.sv
// alu_pipe: parametrised pipelined ALU with internal carry flag, N/V/error flags.
// Latency: LATENCY clock edges from input accept to out_valid (result computed at accept).
// Backpressure: out_valid & ~out_ready stalls the entire pipe and drops in_ready; outputs hold.
//
// Ports: clk/reset (async, active-high); in_valid/in_ready with a, b, ctl, cf_clr on the
// input side; out_valid/out_ready with alu, carry, zero, neg, ovf, err on the output side;
// cf exposes the internal carry flag register.
module alu_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctl,
    input  logic             cf_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err,
    output logic             cf
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    localparam logic [3:0] OP_SEL = 4'd0;
    localparam logic [3:0] OP_INC = 4'd1;
    localparam logic [3:0] OP_DEC = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_ADC = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SBB = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_ROL = 4'd12;
    localparam logic [3:0] OP_ROR = 4'd13;

    typedef struct packed {
        logic [WIDTH-1:0] alu;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic             err;
    } res_t;

    res_t               res;
    logic               legal;
    logic               cin;
    logic [WIDTH:0]     a_x, b_x, cin_x, wide;
    logic               stall, accept;
    res_t               pipe_dat [LATENCY];
    logic [LATENCY-1:0] pipe_vld;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~reset & ~stall;
    assign accept   = in_valid & in_ready;

    // Stage 0: the whole result is formed here; later stages only delay it.
    always_comb begin
        res   = '0;
        legal = 1'b1;
        wide  = '0;
        cin   = cf_clr ? 1'b0 : cf;
        a_x   = {1'b0, a};
        b_x   = {1'b0, b};
        cin_x = {{WIDTH{1'b0}}, cin};
        case (ctl)
            OP_SEL: res.alu = b;
            OP_INC: res.alu = (b == ONES) ? ONES : b + ONE;
            OP_DEC: res.alu = (b == '0) ? '0 : b - ONE;
            OP_ADD, OP_ADC: begin
                wide      = a_x + b_x + ((ctl == OP_ADC) ? cin_x : '0);
                res.alu   = wide[MSB:0];
                res.carry = wide[WIDTH];
                res.ovf   = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBB: begin
                // Bit WIDTH of the extended difference is the borrow.
                wide      = a_x - b_x - ((ctl == OP_SBB) ? cin_x : '0);
                res.alu   = wide[MSB:0];
                res.carry = wide[WIDTH];
                res.ovf   = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_AND: res.alu = a & b;
            OP_OR:  res.alu = a | b;
            OP_XOR: res.alu = a ^ b;
            OP_SHL: begin
                res.alu   = {a[MSB-1:0], 1'b0};
                res.carry = a[MSB];
            end
            OP_SHR: begin
                res.alu   = {1'b0, a[MSB:1]};
                res.carry = a[0];
            end
            OP_ROL: begin
                res.alu   = {a[MSB-1:0], a[MSB]};
                res.carry = a[MSB];
            end
            OP_ROR: begin
                res.alu   = {a[0], a[MSB:1]};
                res.carry = a[0];
            end
            default: begin
                legal   = 1'b0;
                res.err = 1'b1;
            end
        endcase
        // Illegal ops report zero=0 even though alu is 0.
        if (legal) begin
            res.zero = (res.alu == '0);
            res.neg  = res.alu[MSB];
        end
    end

    // Carry flag tracks accepted ops, so ADC/SBB chains need no forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cf <= 1'b0;
        end else if (accept && legal) begin
            cf <= res.carry;
        end else if (cf_clr) begin
            cf <= 1'b0;
        end
    end

    // Delay pipe: every stage moves together; bubbles are carried, not squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else if (!stall) begin
            pipe_vld[0] <= accept;
            pipe_dat[0] <= res;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign out_valid = pipe_vld[LATENCY-1];
    assign alu       = pipe_dat[LATENCY-1].alu;
    assign carry     = pipe_dat[LATENCY-1].carry;
    assign zero      = pipe_dat[LATENCY-1].zero;
    assign neg       = pipe_dat[LATENCY-1].neg;
    assign ovf       = pipe_dat[LATENCY-1].ovf;
    assign err       = pipe_dat[LATENCY-1].err;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8, LATENCY=2).
// Latency: n/a (bench).
// Backpressure: drives out_ready patterns; monitor checks hold and ordering.
module tb_alu_pipe;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic [3:0] ctl;
    logic       cf_clr;
    logic       out_valid, out_ready;
    logic [7:0] alu;
    logic       carry, zero, neg, ovf, err, cf;

    alu_pipe #(.WIDTH(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctl(ctl), .cf_clr(cf_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu(alu), .carry(carry), .zero(zero), .neg(neg),
        .ovf(ovf), .err(err), .cf(cf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] alu;
        logic       carry, zero, neg, ovf, err;
        int         lit;
        int         acc_cyc;
        int         stall_snap;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    logic cf_m = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on 8-bit operands.
    function automatic exp_t model(input int av, input int bv, input int op, input int cin);
        exp_t m;
        int r, sa, sb, sr;
        logic c, ov, e;
        c = 0; ov = 0; e = 0; r = 0;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        case (op)
            0: r = bv;
            1: r = (bv == 255) ? 255 : bv + 1;
            2: r = (bv == 0) ? 0 : bv - 1;
            3, 4: begin
                r  = av + bv + ((op == 4) ? cin : 0);
                c  = (r > 255);
                sr = sa + sb + ((op == 4) ? cin : 0);
                ov = (sr > 127) || (sr < -128);
            end
            5, 6: begin
                r  = av - bv - ((op == 6) ? cin : 0);
                c  = (r < 0);
                sr = sa - sb - ((op == 6) ? cin : 0);
                ov = (sr > 127) || (sr < -128);
            end
            7:  r = av & bv;
            8:  r = av | bv;
            9:  r = av ^ bv;
            10: begin r = av * 2;                  c = (av >= 128); end
            11: begin r = av / 2;                  c = (av % 2) == 1; end
            12: begin r = av * 2 + av / 128;       c = (av >= 128); end
            13: begin r = av / 2 + (av % 2) * 128; c = (av % 2) == 1; end
            default: begin r = 0; e = 1; end
        endcase
        r = r & 255;
        m.alu   = r[7:0];
        m.carry = c;
        m.zero  = !e && (r == 0);
        m.neg   = (r >= 128);
        m.ovf   = ov;
        m.err   = e;
        m.lit   = -1;
        m.acc_cyc = 0;
        m.stall_snap = 0;
        return m;
    endfunction

    // One clock of stimulus; enqueues the expectation if the item is accepted.
    task automatic drive_cycle(input logic v, input logic [7:0] ta, input logic [7:0] tb_v,
                               input logic [3:0] tc, input logic clr, input logic ordy,
                               input int lit, output logic took);
        exp_t e;
        @(posedge clk);
        #1;
        if (!reset) check("cf_reg", cf, cf_m);
        in_valid = v; a = ta; b = tb_v; ctl = tc; cf_clr = clr; out_ready = ordy;
        @(negedge clk);
        took = v && in_ready;
        if (took) begin
            e = model(ta, tb_v, tc, clr ? 0 : cf_m);
            e.lit = lit;
            e.acc_cyc = cyc + 1;
            e.stall_snap = stall_cnt;
            sbq.push_back(e);
            if (!e.err) cf_m = e.carry;
            else if (clr) cf_m = 1'b0;
        end else if (clr) begin
            cf_m = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] tc,
                        input logic clr, input int lit);
        logic took;
        took = 0;
        for (int i = 0; i < 50 && !took; i++) drive_cycle(1, ta, tb_v, tc, clr, 1, lit, took);
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 1, -1, took);
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Monitor: pops the scoreboard on every output transfer, checks hold during stalls.
    exp_t       mon_e;
    logic       prev_stall = 1'b0;
    logic [12:0] held;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {alu, carry, zero, neg, ovf, err}, held);
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                check("in_ready_in_stall", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got alu 0x%0h with empty scoreboard", alu);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", {alu, carry, zero, neg, ovf, err},
                          {mon_e.alu, mon_e.carry, mon_e.zero, mon_e.neg, mon_e.ovf, mon_e.err});
                    if (mon_e.lit >= 0) check("literal_alu", alu, mon_e.lit);
                    if (mon_e.stall_snap == stall_cnt)
                        check("latency", cyc - mon_e.acc_cyc, LAT - 1);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {alu, carry, zero, neg, ovf, err};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic took;
        int   sent;
        reset = 1'b1; in_valid = 0; a = 0; b = 0; ctl = 0; cf_clr = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_outputs", {alu, carry, zero, neg, ovf, err, cf}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed cases.
        send(8'hFF, 8'h01, 4'd3, 0, 8'h00);
        idle(3);
        send(8'h01, 8'h01, 4'd3, 0, 8'h02);
        send(8'h10, 8'h20, 4'd4, 0, 8'h30);
        send(8'h80, 8'h80, 4'd3, 0, 8'h00);
        send(8'h00, 8'h00, 4'd4, 0, 8'h01);
        send(8'h00, 8'h01, 4'd5, 0, 8'hFF);
        send(8'h00, 8'hFF, 4'd1, 0, 8'hFF);
        send(8'h00, 8'h00, 4'd2, 0, 8'h00);
        send(8'hFF, 8'h01, 4'd3, 0, 8'h00);
        send(8'h55, 8'h66, 4'd14, 0, 8'h00);
        send(8'h01, 8'h01, 4'd4, 1, 8'h02);
        idle(4);

        // Backpressure: 5 items, out_ready low for 4 cycles starting at cycle 3.
        sent = 0;
        for (int c = 0; c < 40 && (sent < 5 || sbq.size() > 0); c++) begin
            drive_cycle(sent < 5, rnd8(), rnd8(), 4'($urandom_range(0, 13)), 0,
                        !(c >= 3 && c < 7), -1, took);
            if (took) sent++;
        end
        check("bp_items_sent", sent, 5);
        check("bp_scoreboard_empty", sbq.size(), 0);
        idle(2);

        // Reset with two items in flight.
        for (int i = 0; i < 3; i++) drive_cycle(1, rnd8(), rnd8(), 4'd3, 0, 1, -1, took);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_outputs", {alu, carry, zero, neg, ovf, err, cf}, 0);
        sbq.delete();
        cf_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_cf", cf, 0);
        idle(6);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, rnd8(), rnd8(), 4'($urandom_range(0, 15)),
                        $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, -1, took);
        end

        // Drain.
        for (int i = 0; i < 50 && sbq.size() > 0; i++) idle(1);
        check("drain_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
